// File: rtl/csr_pkg.sv
// CSR execution package: CSR addresses, ALUOP encodings, issue-packet field
// positions, pipeline stage records and the CSR read-modify-write helpers.
// Optional feature macro used by csr_exec_unit: CSR_EXEC_FWD_EN.
package csr_pkg;

    localparam logic [31:0] MTVEC_RESET_DEFAULT = 32'h0000_0100;

    // Machine-mode CSR addresses implemented by csr_regfile
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;

    // ALUOP encodings; every other value behaves as a NOP
    localparam logic [3:0] ALUOP_RW = 4'd1;
    localparam logic [3:0] ALUOP_RS = 4'd2;
    localparam logic [3:0] ALUOP_RC = 4'd3;

    // Issue packet field positions
    localparam int PKT_VALID_BIT = 129;
    localparam int PKT_TAG_MSB   = 128;
    localparam int PKT_TAG_LSB   = 121;
    localparam int PKT_INST_MSB  = 120;
    localparam int PKT_INST_LSB  = 89;
    localparam int PKT_RD_MSB    = 88;
    localparam int PKT_RD_LSB    = 81;
    localparam int PKT_ALUOP_MSB = 80;
    localparam int PKT_ALUOP_LSB = 77;
    localparam int PKT_SRC2_BIT  = 76;
    localparam int PKT_CDATA_MSB = 75;
    localparam int PKT_CDATA_LSB = 44;
    localparam int PKT_ADDR_MSB  = 43;
    localparam int PKT_ADDR_LSB  = 32;
    localparam int PKT_IMM_MSB   = 31;
    localparam int PKT_IMM_LSB   = 0;

    // Instruction held in E1 while the CSR and register operand are read
    typedef struct packed {
        logic        valid;
        logic [7:0]  tag;
        logic [31:0] inst_num;
        logic [7:0]  rd;
        logic [3:0]  aluop;
        logic        src_imm;
        logic [11:0] addr;
        logic [4:0]  uimm;
    } e1_t;

    // Completed result held in E2: writeback fields plus the pending CSR write
    typedef struct packed {
        logic        valid;
        logic [7:0]  rd;
        logic [31:0] inst_num;
        logic [31:0] wb_data;
        logic        illegal;
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
    } e2_t;

    // New CSR value for a read-modify-write
    function automatic logic [31:0] csr_alu_result(input logic [3:0]  aluop,
                                                   input logic [31:0] old_val,
                                                   input logic [31:0] src);
        logic [31:0] res;
        case (aluop)
            ALUOP_RW: res = src;
            ALUOP_RS: res = old_val | src;
            ALUOP_RC: res = old_val & ~src;
            default:  res = old_val;
        endcase
        return res;
    endfunction

    // Set/clear with a zero source must not write (no side effects on read-only use)
    function automatic logic csr_alu_writes(input logic [3:0]  aluop,
                                            input logic [31:0] src);
        logic wr;
        case (aluop)
            ALUOP_RW: wr = 1'b1;
            ALUOP_RS: wr = (src != 32'd0);
            ALUOP_RC: wr = (src != 32'd0);
            default:  wr = 1'b0;
        endcase
        return wr;
    endfunction

    function automatic logic csr_is_op(input logic [3:0] aluop);
        return (aluop == ALUOP_RW) || (aluop == ALUOP_RS) || (aluop == ALUOP_RC);
    endfunction

endpackage

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage: address decode, one combinational read port, one
// write port, free-running mcycle counter and trap capture of mepc/mcause.
module csr_regfile
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = MTVEC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_hit,
    input  logic        wr_en,
    input  logic [11:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic        exception_sig,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_cause,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out
);

    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mcycle_q, mcycle_d;

    // Read decode: unmapped addresses read as zero and report a miss
    always_comb begin
        rd_data = 32'd0;
        rd_hit  = 1'b1;
        case (rd_addr)
            CSR_MSTATUS:  rd_data = mstatus_q;
            CSR_MIE:      rd_data = mie_q;
            CSR_MTVEC:    rd_data = mtvec_q;
            CSR_MSCRATCH: rd_data = mscratch_q;
            CSR_MEPC:     rd_data = mepc_q;
            CSR_MCAUSE:   rd_data = mcause_q;
            CSR_MCYCLE:   rd_data = mcycle_q;
            default:      rd_hit  = 1'b0;
        endcase
    end

    // Next state: explicit write beats the mcycle increment, trap capture beats writes
    always_comb begin
        mstatus_d  = mstatus_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mcycle_d   = mcycle_q + 32'd1;
        if (wr_en) begin
            case (wr_addr)
                CSR_MSTATUS:  mstatus_d  = wr_data;
                CSR_MIE:      mie_d      = wr_data;
                CSR_MTVEC:    mtvec_d    = wr_data;
                CSR_MSCRATCH: mscratch_d = wr_data;
                CSR_MEPC:     mepc_d     = wr_data;
                CSR_MCAUSE:   mcause_d   = wr_data;
                CSR_MCYCLE:   mcycle_d   = wr_data;
                default:      ;
            endcase
        end
        if (exception_sig) begin
            mepc_d   = exc_pc;
            mcause_d = exc_cause;
        end
    end

    // CSR state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mstatus_q  <= 32'd0;
            mie_q      <= 32'd0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= 32'd0;
            mepc_q     <= 32'd0;
            mcause_q   <= 32'd0;
            mcycle_q   <= 32'd0;
        end else begin
            mstatus_q  <= mstatus_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
        end
    end

    assign mtvec_out = mtvec_q;
    assign mepc_out  = mepc_q;

endmodule

// File: rtl/csr_exec_unit.sv
// CSR execution stage: two-stage pipeline (E1 read/compute, E2 writeback and
// CSR commit) behind the CSR reservation station, with flush on trap/mret.
// Optional macro CSR_EXEC_FWD_EN forwards E2's pending write into E1's read.
module csr_exec_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = MTVEC_RESET_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         exception_sig,
    input  logic         mret_sig,
    input  logic [31:0]  exc_pc,
    input  logic [31:0]  exc_cause,
    input  logic [129:0] rs_packet,
    output logic [7:0]   prf_raddr,
    input  logic [31:0]  prf_rdata,
    output logic [7:0]   CSR_phy,
    output logic         CSR_done,
    output logic [31:0]  csr_wb_data,
    output logic [31:0]  csr_wb_inst_num,
    output logic         illegal_csr,
    output logic [31:0]  mtvec_out,
    output logic [31:0]  mepc_out
);

    e1_t e1_q, e1_d;
    e2_t e2_q, e2_d;

    logic        flush;
    logic [31:0] rd_data;
    logic        rd_hit;
    logic [31:0] src_val;
    logic [31:0] old_val;
    logic [31:0] new_val;
    logic        csr_wr_en;

    // The stored csr_data field and the upper immediate bits are never consumed
    logic unused_pkt_bits;
    assign unused_pkt_bits = ^{rs_packet[PKT_CDATA_MSB:PKT_CDATA_LSB], rs_packet[PKT_IMM_MSB:5]};

    assign flush = exception_sig | mret_sig;

    // A flush edge discards the incoming packet along with everything in flight
    always_comb begin
        e1_d = '0;
        if (!flush) begin
            e1_d.valid    = rs_packet[PKT_VALID_BIT];
            e1_d.tag      = rs_packet[PKT_TAG_MSB:PKT_TAG_LSB];
            e1_d.inst_num = rs_packet[PKT_INST_MSB:PKT_INST_LSB];
            e1_d.rd       = rs_packet[PKT_RD_MSB:PKT_RD_LSB];
            e1_d.aluop    = rs_packet[PKT_ALUOP_MSB:PKT_ALUOP_LSB];
            e1_d.src_imm  = rs_packet[PKT_SRC2_BIT];
            e1_d.addr     = rs_packet[PKT_ADDR_MSB:PKT_ADDR_LSB];
            e1_d.uimm     = rs_packet[4:0];
        end
    end

    // E1: operand select, CSR read (optionally forwarded from E2) and ALU
    always_comb begin
        prf_raddr = e1_q.valid ? e1_q.tag : 8'd0;
        src_val   = e1_q.src_imm ? {27'd0, e1_q.uimm} : prf_rdata;
`ifdef CSR_EXEC_FWD_EN
        if (e2_q.valid && e2_q.we && (e2_q.addr == e1_q.addr)) begin
            old_val = e2_q.wdata;
        end else begin
            old_val = rd_data;
        end
`else
        old_val   = rd_data;
`endif
        new_val   = csr_alu_result(e1_q.aluop, old_val, src_val);
    end

    // E2 load: a flush kills the result so no CSR_done follows the flush cycle
    always_comb begin
        e2_d = '0;
        if (!flush && e1_q.valid) begin
            e2_d.valid    = 1'b1;
            e2_d.rd       = e1_q.rd;
            e2_d.inst_num = e1_q.inst_num;
            e2_d.wb_data  = csr_is_op(e1_q.aluop) ? old_val : 32'd0;
            e2_d.illegal  = ~rd_hit;
            e2_d.we       = csr_alu_writes(e1_q.aluop, src_val) & rd_hit;
            e2_d.addr     = e1_q.addr;
            e2_d.wdata    = new_val;
        end
    end

    // Pipeline stage registers
    always_ff @(posedge clk) begin
        if (reset) begin
            e1_q <= '0;
            e2_q <= '0;
        end else begin
            e1_q <= e1_d;
            e2_q <= e2_d;
        end
    end

    // An E2 write still pending when a flush arrives is dropped
    assign csr_wr_en = e2_q.valid & e2_q.we & ~flush;

    csr_regfile #(
        .MTVEC_RESET (MTVEC_RESET)
    ) u_regfile (
        .clk           (clk),
        .reset         (reset),
        .rd_addr       (e1_q.addr),
        .rd_data       (rd_data),
        .rd_hit        (rd_hit),
        .wr_en         (csr_wr_en),
        .wr_addr       (e2_q.addr),
        .wr_data       (e2_q.wdata),
        .exception_sig (exception_sig),
        .exc_pc        (exc_pc),
        .exc_cause     (exc_cause),
        .mtvec_out     (mtvec_out),
        .mepc_out      (mepc_out)
    );

    assign CSR_done        = e2_q.valid;
    assign CSR_phy         = e2_q.rd;
    assign csr_wb_data     = e2_q.wb_data;
    assign csr_wb_inst_num = e2_q.inst_num;
    assign illegal_csr     = e2_q.illegal;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Scoreboard bench for csr_exec_unit: directed CSR instructions push their
// hand-computed writeback into a queue; a monitor pops on every CSR_done.
module tb_csr_exec_unit;
    import csr_pkg::*;

    logic         clk;
    logic         reset;
    logic         exception_sig;
    logic         mret_sig;
    logic [31:0]  exc_pc;
    logic [31:0]  exc_cause;
    logic [129:0] rs_packet;
    logic [7:0]   prf_raddr;
    logic [31:0]  prf_rdata;
    logic [7:0]   CSR_phy;
    logic         CSR_done;
    logic [31:0]  csr_wb_data;
    logic [31:0]  csr_wb_inst_num;
    logic         illegal_csr;
    logic [31:0]  mtvec_out;
    logic [31:0]  mepc_out;

    typedef struct {
        logic [7:0]  phy;
        logic [31:0] data;
        logic [31:0] inst;
        logic        illegal;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_exp;
    int   compared   = 0;
    int   mismatched = 0;
    int   inst_ctr   = 0;
    logic [31:0] fwd_exp;

    csr_exec_unit dut (
        .clk             (clk),
        .reset           (reset),
        .exception_sig   (exception_sig),
        .mret_sig        (mret_sig),
        .exc_pc          (exc_pc),
        .exc_cause       (exc_cause),
        .rs_packet       (rs_packet),
        .prf_raddr       (prf_raddr),
        .prf_rdata       (prf_rdata),
        .CSR_phy         (CSR_phy),
        .CSR_done        (CSR_done),
        .csr_wb_data     (csr_wb_data),
        .csr_wb_inst_num (csr_wb_inst_num),
        .illegal_csr     (illegal_csr),
        .mtvec_out       (mtvec_out),
        .mepc_out        (mepc_out)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical register file model: tag 5 and tag 6 hold known values
    assign prf_rdata = (prf_raddr == 8'd5) ? 32'hDEAD_BEEF :
                       (prf_raddr == 8'd6) ? 32'h0000_0005 : 32'h0000_0000;

    // Watchdog so a stuck run still ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run did not finish (got timeout, wanted finish)");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [129:0] buildPacket(input logic [3:0] aluop, input logic src_imm,
                                                 input logic [7:0] tag, input logic [7:0] rd,
                                                 input logic [11:0] addr, input logic [4:0] uimm,
                                                 input logic [31:0] inst);
        logic [129:0] p;
        p = '0;
        p[PKT_VALID_BIT]               = 1'b1;
        p[PKT_TAG_MSB:PKT_TAG_LSB]     = tag;
        p[PKT_INST_MSB:PKT_INST_LSB]   = inst;
        p[PKT_RD_MSB:PKT_RD_LSB]       = rd;
        p[PKT_ALUOP_MSB:PKT_ALUOP_LSB] = aluop;
        p[PKT_SRC2_BIT]                = src_imm;
        p[PKT_CDATA_MSB:PKT_CDATA_LSB] = 32'hA5A5_A5A5;
        p[PKT_ADDR_MSB:PKT_ADDR_LSB]   = addr;
        p[PKT_IMM_MSB:PKT_IMM_LSB]     = {27'h1234567, uimm};
        return p;
    endfunction

    // Drive one packet for one cycle and record its expected writeback
    task automatic applyStimulus(input logic [3:0] aluop, input logic src_imm, input logic [7:0] tag,
                                 input logic [7:0] rd, input logic [11:0] addr, input logic [4:0] uimm,
                                 input logic expect_done, input logic [31:0] exp_data,
                                 input logic exp_illegal);
        exp_t e;
        rs_packet = buildPacket(aluop, src_imm, tag, rd, addr, uimm, inst_ctr);
        if (expect_done) begin
            e.phy     = rd;
            e.data    = exp_data;
            e.inst    = inst_ctr;
            e.illegal = exp_illegal;
            sb_q.push_back(e);
        end
        inst_ctr++;
        @(negedge clk);
        rs_packet = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Direct comparison of a sampled value against a bench constant
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every CSR_done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && CSR_done) begin
            compared++;
            if (sb_q.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_done: got done phy=%0d data=0x%08h inst=%0d, wanted no done",
                         CSR_phy, csr_wb_data, csr_wb_inst_num);
            end else begin
                mon_exp = sb_q.pop_front();
                if (CSR_phy !== mon_exp.phy || csr_wb_data !== mon_exp.data ||
                    csr_wb_inst_num !== mon_exp.inst || illegal_csr !== mon_exp.illegal) begin
                    mismatched++;
                    $display("[TB] FAIL wb inst %0d: got phy=%0d data=0x%08h inst=%0d ill=%0b, wanted phy=%0d data=0x%08h inst=%0d ill=%0b",
                             mon_exp.inst, CSR_phy, csr_wb_data, csr_wb_inst_num, illegal_csr,
                             mon_exp.phy, mon_exp.data, mon_exp.inst, mon_exp.illegal);
                end
            end
        end
    end

    // Directed sequence
    initial begin
`ifdef CSR_EXEC_FWD_EN
        fwd_exp = 32'h0000_0001;
`else
        fwd_exp = 32'hDEAD_BEEF;
`endif
        reset         = 1'b1;
        exception_sig = 1'b0;
        mret_sig      = 1'b0;
        exc_pc        = 32'd0;
        exc_cause     = 32'd0;
        rs_packet     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        checkOutput("rst_done", {31'd0, CSR_done}, 32'd0);
        checkOutput("rst_phy", {24'd0, CSR_phy}, 32'd0);
        checkOutput("rst_wb_data", csr_wb_data, 32'd0);
        checkOutput("rst_illegal", {31'd0, illegal_csr}, 32'd0);
        checkOutput("rst_prf_raddr", {24'd0, prf_raddr}, 32'd0);
        checkOutput("rst_mtvec", mtvec_out, 32'h0000_0100);
        checkOutput("rst_mepc", mepc_out, 32'd0);

        // mcycle is 0 in this cycle, k after k more cycles; read lands in E1 at count 10
        reset = 1'b0;
        idle(9);
        applyStimulus(ALUOP_RS, 1'b1, 8'd0, 8'd1, CSR_MCYCLE, 5'd0, 1'b1, 32'd10, 1'b0);
        applyStimulus(ALUOP_RW, 1'b1, 8'd0, 8'd2, CSR_MCYCLE, 5'd0, 1'b1, 32'd11, 1'b0);
        idle(1);
        applyStimulus(ALUOP_RS, 1'b1, 8'd0, 8'd3, CSR_MCYCLE, 5'd0, 1'b1, 32'd0, 1'b0);
        applyStimulus(ALUOP_RS, 1'b1, 8'd0, 8'd3, CSR_MCYCLE, 5'd0, 1'b1, 32'd1, 1'b0);

        // CSRRW from register tag 5 into mscratch, then read back
        applyStimulus(ALUOP_RW, 1'b0, 8'd5, 8'd9, CSR_MSCRATCH, 5'd0, 1'b1, 32'd0, 1'b0);
        idle(1);
        applyStimulus(ALUOP_RS, 1'b1, 8'd0, 8'd10, CSR_MSCRATCH, 5'd0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        idle(1);

        // Back-to-back same-address writes
        applyStimulus(ALUOP_RW, 1'b1, 8'd0, 8'd11, CSR_MSCRATCH, 5'd1, 1'b1, 32'hDEAD_BEEF, 1'b0);
        applyStimulus(ALUOP_RW, 1'b1, 8'd0, 8'd12, CSR_MSCRATCH, 5'd2, 1'b1, fwd_exp, 1'b0);
        idle(1);
        applyStimulus(ALUOP_RS, 1'b1, 8'd0, 8'd13, CSR_MSCRATCH, 5'd0, 1'b1, 32'd2, 1'b0);
        idle(1);

        // mstatus: set to 0xF, RSI 0 (no write), RCI 8, read back 0x7
        applyStimulus(ALUOP_RW, 1'b1, 8'd0, 8'd14, CSR_MSTATUS, 5'hF, 1'b1, 32'd0, 1'b0);
        idle(1);
        applyStimulus(ALUOP_RS, 1'b1, 8'd0, 8'd15, CSR_MSTATUS, 5'd0, 1'b1, 32'hF, 1'b0);
        idle(1);
        applyStimulus(ALUOP_RC, 1'b1, 8'd0, 8'd16, CSR_MSTATUS, 5'd8, 1'b1, 32'hF, 1'b0);
        idle(1);
        applyStimulus(ALUOP_RS, 1'b1, 8'd0, 8'd17, CSR_MSTATUS, 5'd0, 1'b1, 32'h7, 1'b0);
        idle(1);

        // Unmapped address: illegal, reads zero, write dropped
        applyStimulus(ALUOP_RW, 1'b1, 8'd0, 8'd18, 12'h7C0, 5'd5, 1'b1, 32'd0, 1'b1);
        idle(1);
        applyStimulus(ALUOP_RS, 1'b0, 8'd5, 8'd19, 12'h7C0, 5'd0, 1'b1, 32'd0, 1'b1);
        idle(1);

        // NOP ALUOP: done with zero data, mscratch untouched
        applyStimulus(4'd0, 1'b1, 8'd0, 8'd20, CSR_MSCRATCH, 5'd7, 1'b1, 32'd0, 1'b0);
        idle(1);
        applyStimulus(ALUOP_RS, 1'b1, 8'd0, 8'd21, CSR_MSCRATCH, 5'd0, 1'b1, 32'd2, 1'b0);
        idle(1);

        // mie: write 0x1F, clear with register tag 6 (=5), expect 0x1A
        applyStimulus(ALUOP_RW, 1'b1, 8'd0, 8'd22, CSR_MIE, 5'h1F, 1'b1, 32'd0, 1'b0);
        idle(1);
        applyStimulus(ALUOP_RC, 1'b0, 8'd6, 8'd23, CSR_MIE, 5'd0, 1'b1, 32'h1F, 1'b0);
        idle(1);
        applyStimulus(ALUOP_RS, 1'b1, 8'd0, 8'd24, CSR_MIE, 5'd0, 1'b1, 32'h1A, 1'b0);
        idle(1);

        // mtvec reset value, then overwrite and observe mtvec_out
        applyStimulus(ALUOP_RW, 1'b1, 8'd0, 8'd25, CSR_MTVEC, 5'h1C, 1'b1, 32'h0000_0100, 1'b0);
        idle(2);
        checkOutput("mtvec_written", mtvec_out, 32'h0000_001C);

        // Exception while the packet sits in E1: no done, trap captured
        applyStimulus(ALUOP_RW, 1'b1, 8'd0, 8'd26, CSR_MEPC, 5'd3, 1'b0, 32'd0, 1'b0);
        exception_sig = 1'b1;
        exc_pc        = 32'h0000_0200;
        exc_cause     = 32'd2;
        @(negedge clk);
        exception_sig = 1'b0;
        exc_pc        = 32'd0;
        exc_cause     = 32'd0;
        checkOutput("mepc_trap", mepc_out, 32'h0000_0200);
        idle(1);
        applyStimulus(ALUOP_RS, 1'b1, 8'd0, 8'd27, CSR_MCAUSE, 5'd0, 1'b1, 32'd2, 1'b0);
        applyStimulus(ALUOP_RS, 1'b1, 8'd0, 8'd28, CSR_MEPC, 5'd0, 1'b1, 32'h0000_0200, 1'b0);
        idle(1);

        // mret with A in E1 and B on the input: both discarded
        applyStimulus(ALUOP_RW, 1'b1, 8'd0, 8'd29, CSR_MSCRATCH, 5'd9, 1'b0, 32'd0, 1'b0);
        rs_packet = buildPacket(ALUOP_RW, 1'b1, 8'd0, 8'd30, CSR_MSTATUS, 5'd1, inst_ctr);
        inst_ctr++;
        mret_sig  = 1'b1;
        @(negedge clk);
        rs_packet = '0;
        mret_sig  = 1'b0;
        idle(1);
        applyStimulus(ALUOP_RS, 1'b1, 8'd0, 8'd31, CSR_MSCRATCH, 5'd0, 1'b1, 32'd2, 1'b0);
        applyStimulus(ALUOP_RS, 1'b1, 8'd0, 8'd32, CSR_MSTATUS, 5'd0, 1'b1, 32'h7, 1'b0);
        idle(1);

        // mret while the write is in E2: done still seen, write dropped
        applyStimulus(ALUOP_RW, 1'b1, 8'd0, 8'd33, CSR_MSCRATCH, 5'd9, 1'b1, 32'd2, 1'b0);
        idle(1);
        mret_sig = 1'b1;
        @(negedge clk);
        mret_sig = 1'b0;
        applyStimulus(ALUOP_RS, 1'b1, 8'd0, 8'd34, CSR_MSCRATCH, 5'd0, 1'b1, 32'd2, 1'b0);

        idle(4);
        checkOutput("sb_drain", sb_q.size(), 32'd0);
        checkOutput("prf_raddr_idle", {24'd0, prf_raddr}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/csr_exec_unit.md
# csr_exec_unit

Execution stage for CSR instructions, directly downstream of the CSR reservation station. Consumes the station's 130-bit issue packet, reads the source operand from the physical register file, and executes CSRRW/CSRRS/CSRRC and their immediate forms against an internal machine-mode CSR file. Writes the old CSR value back to the destination physical register and broadcasts `CSR_phy`/`CSR_done` so the reservation stations wake dependents. Also captures `mepc`/`mcause` on exceptions and supplies `mtvec`/`mepc` to the fetch redirect logic.

## Interface
- `MTVEC_RESET`, default 32'h0000_0100, reset value of `mtvec`
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high; clock clk
- `exception_sig`  in  1  flush plus trap capture
- `mret_sig`  in  1  flush
- `exc_pc`  in  32  PC of the trapping instruction, valid with `exception_sig`
- `exc_cause`  in  32  cause code, valid with `exception_sig`
- `rs_packet`  in  130  issue packet: [129] valid, [128:121] operand1 tag, [120:89] inst_num, [88:81] Rd, [80:77] ALUOP, [76] ALUSrc2, [75:44] csr_data (ignored), [43:32] csr_addr, [31:0] immediate
- `prf_raddr`  out  8  physical register read tag (combinational read port)
- `prf_rdata`  in  32  read data, same cycle
- `CSR_phy`  out  8  destination physical register
- `CSR_done`  out  1  writeback/wakeup strobe
- `csr_wb_data`  out  32  old CSR value written to `CSR_phy`
- `csr_wb_inst_num`  out  32  instruction number, for ROB completion
- `illegal_csr`  out  1  qualifies `CSR_done`: unmapped address
- `mtvec_out`, `mepc_out`  out  32 each  current CSR values

## Operation
- ALUOP: 1 = CSRRW, 2 = CSRRS, 3 = CSRRC. Any other value is treated as a NOP: `CSR_done` is still asserted, no CSR write occurs, and `csr_wb_data` = 0.
- Source value: ALUSrc2 = 1 selects `{27'b0, immediate[4:0]}`; otherwise `prf_rdata`.
- New value:
  - RW: src.
  - RS: old | src.
  - RC: old & ~src.
  - RS and RC with src == 0 perform no write.
- Mapped CSRs, all resetting to 0 except `mtvec`: 0x300 mstatus, 0x304 mie, 0x305 mtvec, 0x340 mscratch, 0x341 mepc, 0x342 mcause, 0xB00 mcycle.
- Unmapped address: reads 0, write dropped, `illegal_csr` = 1 with `CSR_done`.
- `mcycle` increments by 1 every cycle and wraps at 2^32. A CSR write to `mcycle` in the same cycle wins over the increment.
- Priority at each edge: reset > exception_sig > mret_sig > E2 CSR write.
  - Exception: `mepc` <= `exc_pc`, `mcause` <= `exc_cause`.
  - Exception and mret both clear E1/E2 valid; any in-flight write is dropped.
- All outputs reset to 0, except `mtvec_out` = `MTVEC_RESET`.

## Timing
- Pipeline:
  - Cycle T: packet with bit 129 set is sampled into E1.
  - T+1 (E1): `prf_raddr` = tag, CSR read, new value computed, result latched into E2.
  - T+2 (E2): `CSR_done` = 1 for exactly one cycle; CSR write commits at the end of T+2.
- Latency is 2 cycles. Throughput is 1 packet per cycle. There is no backpressure, because the station has no ready input.
- Back-to-back same-address ops: B's E1 overlaps A's E2 (see Configuration).
- `prf_raddr` = 0 when E1 is empty.
- Flush in cycle F: no `CSR_done` in F+1 from any packet sampled at or before F.
- Packet present during a flush edge: discarded.

## Configuration
- `CSR_EXEC_FWD_EN`
  - Defined: E1 read of an address equal to E2's pending write address returns E2's new value.
  - Undefined: E1 returns the committed value, so B observes the pre-A value. Dispatch must then separate same-address CSR ops by ≥1 cycle.

## Structure
- `csr_pkg`: CSR address constants, ALUOP codes, packet field MSB/LSB localparams, `MTVEC_RESET` default.
- Sub-module `csr_regfile`: the CSR storage, address decode, `mcycle` counter, and trap capture. It has one combinational read port and one write port.
- `csr_exec_unit` holds the E1/E2 pipeline registers, the operand mux and ALU, forwarding, and flush logic.

## Test plan
- CSRRW x(tag 5 = 0xDEAD_BEEF) to 0x340, Rd 9 → at T+2: `CSR_done`=1, `CSR_phy`=9, `csr_wb_data`=0; a subsequent read of 0x340 returns 0xDEAD_BEEF.
- CSRRSI 0x300 uimm 0, then CSRRCI 0x300 uimm 0x8 on mstatus=0xF → first op performs no write; second leaves mstatus=0x7, `csr_wb_data`=0xF.
- Back-to-back CSRRW 0x340 ← 1, then CSRRW 0x340 ← 2 → second `csr_wb_data`:
  - 1 with `CSR_EXEC_FWD_EN`.
  - Prior value without it.
- Access to 0x7C0 → `illegal_csr`=1 with `CSR_done`, `csr_wb_data`=0, no state change.
- Packet at T, `exception_sig` at T+1 with `exc_pc`=0x200, `exc_cause`=2 → no `CSR_done` at T+2; `mepc_out`=0x200, mcause=2.
- Reset, then idle 10 cycles → `mcycle` read returns 10 ±pipeline offset (exact: value at E1 cycle); CSRRW 0xB00 ← 0 restarts the count from 0 the next cycle.
